// File: rtl/nic_flit_injector.sv
// nic_flit_injector: network-interface injection stage feeding one router input port.
// Turns packet descriptors plus a payload stream into head/body/tail flits on one VC,
// and tracks per-VC downstream credits so router input buffers are never overrun.
// Optional statistics counters are enabled by defining NIC_INJ_STATS_EN.
module nic_flit_injector #(
  parameter int NUM_VCS    = 2,
  parameter int DATA_WIDTH = 64,
  parameter int BUF_DEPTH  = 8,
  parameter int DEST_WIDTH = 2,
  parameter int LEN_WIDTH  = 4,
  localparam int VC_IDX_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CRED_W    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                desc_valid,
  output logic                                desc_ready,
  input  logic [VC_IDX_W-1:0]                 desc_vc,
  input  logic [DEST_WIDTH-1:0]               desc_dest,
  input  logic [LEN_WIDTH-1:0]                desc_len,
  input  logic                                data_valid,
  output logic                                data_ready,
  input  logic [DATA_WIDTH-1:0]               data,
  output logic [3+NUM_VCS+DATA_WIDTH-1:0]     channel_out,
  input  logic [NUM_VCS:0]                    flow_ctrl_in,
  output logic [NUM_VCS*CRED_W-1:0]           credit_count,
`ifdef NIC_INJ_STATS_EN
  output logic [31:0]                         flit_count,
  output logic [31:0]                         pkt_count,
  output logic [31:0]                         stall_cycles,
`endif
  output logic                                error
);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

  state_t                          r_state, w_nextState;
  logic [VC_IDX_W-1:0]             r_vc;
  logic [DEST_WIDTH-1:0]           r_dest;
  logic [LEN_WIDTH-1:0]            r_len;
  logic [LEN_WIDTH-1:0]            r_remaining;
  logic [CRED_W-1:0]               r_credit [NUM_VCS];
  logic [CRED_W-1:0]               w_creditNext [NUM_VCS];
  logic [3+NUM_VCS+DATA_WIDTH-1:0] r_channel;
  logic                            r_error;

  logic                            w_hasCredit;
  logic                            w_send;
  logic                            w_head;
  logic                            w_tail;
  logic                            w_descAccept;
  logic                            w_descBad;
  logic                            w_creditErr;
  logic [DATA_WIDTH-1:0]           w_flitData;
  logic [NUM_VCS-1:0]              w_vcOneHot;
  logic                            w_retValid;
  logic                            w_retLegal;
  logic [NUM_VCS-1:0]              w_retVec;

  assign w_retValid  = flow_ctrl_in[NUM_VCS];
  assign w_retVec    = flow_ctrl_in[NUM_VCS-1:0];
  assign w_retLegal  = w_retValid && $onehot(w_retVec);
  assign w_hasCredit = (r_credit[r_vc] != '0);
  assign channel_out = r_channel;
  assign error       = r_error;

  // Packet sequencing: decides when a head or body flit goes out and drives the handshakes.
  always_comb begin
    w_nextState  = r_state;
    desc_ready   = 1'b0;
    data_ready   = 1'b0;
    w_send       = 1'b0;
    w_head       = 1'b0;
    w_tail       = 1'b0;
    w_flitData   = '0;
    w_descAccept = 1'b0;
    w_descBad    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          if (int'(desc_vc) < NUM_VCS) begin
            w_descAccept = 1'b1;
            w_nextState  = S_HEAD;
          end else begin
            w_descBad = 1'b1;
          end
        end
      end
      S_HEAD: begin
        if (w_hasCredit) begin
          w_send      = 1'b1;
          w_head      = 1'b1;
          w_flitData  = DATA_WIDTH'({r_len, r_dest});
          w_tail      = (r_len == LEN_WIDTH'(1));
          w_nextState = w_tail ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        data_ready = w_hasCredit;
        if (data_valid && w_hasCredit) begin
          w_send     = 1'b1;
          w_flitData = data;
          w_tail     = (r_remaining == LEN_WIDTH'(1));
          if (w_tail) begin
            w_nextState = S_IDLE;
          end
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // One-hot VC field of outgoing flits.
  always_comb begin
    w_vcOneHot       = '0;
    w_vcOneHot[r_vc] = 1'b1;
  end

  // State register; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Descriptor capture and remaining-flit count; a zero length is promoted to one flit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vc        <= '0;
      r_dest      <= '0;
      r_len       <= '0;
      r_remaining <= '0;
    end else begin
      if (w_descAccept) begin
        r_vc   <= desc_vc;
        r_dest <= desc_dest;
        r_len  <= (desc_len == '0) ? LEN_WIDTH'(1) : desc_len;
      end
      if (w_send) begin
        r_remaining <= w_head ? (r_len - 1'b1) : (r_remaining - 1'b1);
      end
    end
  end

  // Registered channel: each flit is valid for exactly one cycle, zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_channel <= '0;
    end else if (w_send) begin
      r_channel <= {1'b1, w_head, w_tail, w_vcOneHot, w_flitData};
    end else begin
      r_channel <= '0;
    end
  end

  // Credit update: a send and a return on the same VC cancel; saturate and flag on overflow.
  always_comb begin
    w_creditErr = w_retValid && !w_retLegal;
    for (int i = 0; i < NUM_VCS; i++) begin
      logic inc;
      logic dec;
      inc             = w_retLegal && w_retVec[i];
      dec             = w_send && (int'(r_vc) == i);
      w_creditNext[i] = r_credit[i];
      if (inc && !dec) begin
        if (r_credit[i] == CRED_W'(BUF_DEPTH)) begin
          w_creditErr = 1'b1;
        end else begin
          w_creditNext[i] = r_credit[i] + 1'b1;
        end
      end else if (dec && !inc) begin
        if (r_credit[i] == '0) begin
          w_creditErr = 1'b1;
        end else begin
          w_creditNext[i] = r_credit[i] - 1'b1;
        end
      end
    end
  end

  // Credit counters start full, matching the freshly reset router buffers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VCS; i++) begin
        r_credit[i] <= CRED_W'(BUF_DEPTH);
      end
    end else begin
      for (int i = 0; i < NUM_VCS; i++) begin
        r_credit[i] <= w_creditNext[i];
      end
    end
  end

  // Sticky error flag for bad credit traffic or an out-of-range descriptor VC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else begin
      r_error <= r_error | w_creditErr | w_descBad;
    end
  end

  // Pack the per-VC credit counters, VC0 in the least significant bits.
  always_comb begin
    credit_count = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      credit_count[i*CRED_W +: CRED_W] = r_credit[i];
    end
  end

`ifdef NIC_INJ_STATS_EN
  logic [31:0] r_flitCount;
  logic [31:0] r_pktCount;
  logic [31:0] r_stallCycles;

  assign flit_count   = r_flitCount;
  assign pkt_count    = r_pktCount;
  assign stall_cycles = r_stallCycles;

  // Free-running statistics; all wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flitCount   <= '0;
      r_pktCount    <= '0;
      r_stallCycles <= '0;
    end else begin
      if (w_send) begin
        r_flitCount <= r_flitCount + 32'd1;
      end
      if (w_send && w_tail) begin
        r_pktCount <= r_pktCount + 32'd1;
      end
      if ((r_state != S_IDLE) && !w_hasCredit) begin
        r_stallCycles <= r_stallCycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/nic_flit_injector.md
Name: nic_flit_injector

Overview:
- Network-interface injection stage. Sits directly upstream of a router input port and drives that port's channel.
- Accepts packet descriptors plus a payload word stream, and segments each packet into head/body/tail flits on a chosen VC.
- Tracks per-VC downstream credits from the router's flow-control output and never overruns router input buffers.

Parameters:
- NUM_VCS, 2, virtual channels on the link (>=1).
- DATA_WIDTH, 64, flit payload bits.
- BUF_DEPTH, 8, router input-buffer depth per VC; reset value of each credit counter.
- DEST_WIDTH, 2, destination router address bits.
- LEN_WIDTH, 4, packet-length field bits (flits, including head).
- Derived: VC_IDX_W = max(1, clog2(NUM_VCS)); CRED_W = clog2(BUF_DEPTH+1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- desc_valid  in  1  packet descriptor valid.
- desc_ready  out  1  descriptor accepted when valid & ready.
- desc_vc  in  VC_IDX_W  target VC.
- desc_dest  in  DEST_WIDTH  destination router address.
- desc_len  in  LEN_WIDTH  total flits; 0 is treated as 1.
- data_valid  in  1  payload word valid.
- data_ready  out  1  payload word consumed when valid & ready.
- data  in  DATA_WIDTH  body/tail payload.
- channel_out  out  3+NUM_VCS+DATA_WIDTH  {flit_valid, head, tail, vc one-hot, flit_data}.
- flow_ctrl_in  in  1+NUM_VCS  {credit_valid, credit vc one-hot} from router.
- credit_count  out  NUM_VCS*CRED_W  current credits, VC0 in LSBs.
- error  out  1  sticky credit overflow/underflow or illegal credit vector.

Behaviour:
- Reset (reset low, asynchronous):
  - state IDLE; all credit counters = BUF_DEPTH; channel_out = 0; desc_ready = 1; data_ready = 0; error = 0.
- FSM IDLE:
  - desc_ready = 1.
  - On accept, latch vc, dest and len (len 0 becomes 1). Go to HEAD.
- FSM HEAD:
  - desc_ready = 0.
  - When credit[vc] > 0, emit the head flit next cycle. Head flit_data = {zero pad, len, dest}, with dest in the LSBs.
  - tail = 1 if len == 1, then go to IDLE. Otherwise remaining = len-1 and go to BODY.
  - If credit[vc] == 0, stall in HEAD; channel flit_valid stays 0.
- FSM BODY:
  - data_ready = (credit[vc] > 0), combinational.
  - On data accept, emit a flit carrying data next cycle; remaining decrements.
  - The flit with remaining == 1 carries tail = 1 and returns to IDLE.
  - Head is 0 for all body flits.
- channel_out is registered: each flit is valid for exactly one cycle, and flit_valid = 0 on idle cycles.
- Latency:
  - Descriptor accept to head flit valid: 2 cycles with credits available.
  - Data accept to flit valid: 1 cycle.
- Throughput: one body flit per cycle when credits and data are available.
- Credits:
  - A sent flit decrements credit[vc].
  - credit_valid with one-hot bit i increments credit[i].
  - A simultaneous send and return on the same VC leaves the count unchanged.
- Error conditions (each sets error = 1, sticky until reset):
  - Credit return would exceed BUF_DEPTH: the counter saturates.
  - credit_valid with a non-one-hot vector: the credit is ignored.
  - desc_vc >= NUM_VCS: the descriptor is dropped, FSM stays in IDLE.
- Back-pressure boundary:
  - Credit reaching 0 mid-packet stalls BODY with no partial flit.
  - The packet resumes the cycle after a credit return.
- Reset asserted mid-packet aborts the packet. The router is reset on the same signal, so credits reinitialise consistently.

Optional Feature:
- Macro: NIC_INJ_STATS_EN.
- Defined: adds outputs flit_count (32 bits) and pkt_count (32 bits).
  - Both zero on reset.
  - flit_count increments per emitted flit; pkt_count increments per emitted tail flit.
  - Both wrap at 2^32.
  - Also adds stall_cycles (32 bits): increments each cycle in HEAD/BODY with credit[vc] == 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single-flit packet: desc vc=0, dest=2'b01, len=1 -> 2 cycles later one flit, valid=1, head=1, tail=1, vc=2'b01, data[1:0]=01; credit0 = 7.
- 4-flit packet, vc=1, data 0xA..0xC streamed -> head then 3 consecutive flits, tail only on 0xC, vc=2'b10; credit1 = 4.
- Credit starvation: BUF_DEPTH=8, send a 10-flit packet with no returns -> 8 flits sent, data_ready=0, stall. Return one credit -> next flit 1 cycle later.
- Simultaneous send and credit return on VC0 at credit=3 -> credit stays 3.
- Spurious credit on VC1 at credit=8 -> counter stays 8, error=1 and remains 1 until reset.
- Assert reset mid-BODY -> channel_out=0 immediately, credits=8, FSM IDLE, desc_ready=1.
